// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the
// registered status-flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADC    = 3'd0,
        OP_ADD    = 3'd1,
        OP_MAX    = 3'd2,
        OP_SHLADD = 3'd3,
        OP_SHRADD = 3'd4,
        OP_ABS    = 3'd5,
        OP_ADD2B  = 3'd6,
        OP_AND    = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic co;
        logic ov;
        logic z;
        logic neg;
        logic agb;
        logic eq;
    } alu_flags_t;

    function automatic logic is_shift_op(op_e op);
        return (op == OP_SHLADD) || (op == OP_SHRADD);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result/flag computation for all eight ALU operations.
// Ports: a, b operands; sh pre-shifted a (ops 3/4); op; ci -> w, f.
import alu_pkg::*;

module alu_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] sh,
    input  op_e          op,
    input  logic         ci,
    output logic [W-1:0] w,
    output alu_flags_t   f
);

    logic [W:0]   sum1;
    logic [W+1:0] sum2;
    logic [W+1:0] ex2;

    always_comb begin
        sum1 = '0;
        sum2 = '0;
        ex2  = '0;
        w    = '0;
        f    = '0;
        unique case (op)
            OP_ADC, OP_ADD: begin
                sum1 = {1'b0, a} + {1'b0, b}
                     + {{W{1'b0}}, ci & (op == OP_ADC)};
                w    = sum1[W-1:0];
                f.co = sum1[W];
                f.ov = (a[W-1] == b[W-1]) && (w[W-1] != a[W-1]);
            end
            OP_MAX: begin
                w = ($signed(a) > $signed(b)) ? a : b;
            end
            OP_SHLADD, OP_SHRADD: begin
                w    = a + sh;
                f.ov = (a[W-1] == sh[W-1]) && (w[W-1] != a[W-1]);
            end
            OP_ABS: begin
                w    = a[W-1] ? (~a + W'(1)) : a;
                // Negating the most-negative value wraps back onto itself.
                f.ov = a[W-1] && (a[W-2:0] == '0);
            end
            OP_ADD2B: begin
                sum2 = {2'b00, a} + {2'b00, b} + {2'b00, b};
                // Sign-extended to W+2 bits, a+2b can never overflow.
                ex2  = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b}
                     + {{2{b[W-1]}}, b};
                w    = sum2[W-1:0];
                f.co = sum2[W];
                f.ov = (ex2[W+1:W-1] != 3'b000)
                    && (ex2[W+1:W-1] != 3'b111);
            end
            OP_AND: begin
                w = a & b;
            end
        endcase
        f.z   = (w == '0);
        f.neg = w[W-1];
        f.agb = $signed(a) > $signed(b);
        f.eq  = (a == b);
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU with a one-bit-per-cycle shifter for ops 3/4.
// Ports: start/ready accept; a, b, s, n, ci operands; done pulse, w, flags.
import alu_pkg::*;

module alu_seq #(
    parameter int W  = 8,
    parameter int NW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [2:0]    s,
    input  logic [NW-1:0] n,
    input  logic          ci,
    output logic          ready,
    output logic          done,
    output logic [W-1:0]  w,
    output logic          co,
    output logic          ov,
    output logic          z,
    output logic          neg,
    output logic          agb,
    output logic          eq
);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    op_e           s_q, s_d;
    logic          ci_q, ci_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  w_q, w_d;
    alu_flags_t    fl_q, fl_d;
    logic          done_q, done_d;

    logic [W-1:0]  core_a, core_b, core_sh, core_w;
    op_e           core_op, s_in;
    logic          core_ci, accept;
    alu_flags_t    core_f;

    assign ready  = (state_q == IDLE) && !rst;
    assign accept = start && ready;
    assign s_in   = op_e'(s);

    // Single-cycle ops finish on the accept edge, so in IDLE the core
    // sees the live inputs; in SHIFT it sees the latched operands.
    always_comb begin
        if (state_q == IDLE) begin
            core_a  = a;
            core_b  = b;
            core_sh = a;
            core_op = s_in;
            core_ci = ci;
        end else begin
            core_a  = a_q;
            core_b  = b_q;
            core_sh = sh_q;
            core_op = s_q;
            core_ci = ci_q;
        end
    end

    alu_core #(.W(W)) u_core (
        .a  (core_a),
        .b  (core_b),
        .sh (core_sh),
        .op (core_op),
        .ci (core_ci),
        .w  (core_w),
        .f  (core_f)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        ci_d    = ci_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        fl_d    = fl_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d  = a;
                    b_d  = b;
                    s_d  = s_in;
                    ci_d = ci;
                    if (is_shift_op(s_in)) begin
                        state_d = SHIFT;
                        sh_d    = a;
                        cnt_d   = n;
                    end else begin
                        w_d    = core_w;
                        fl_d   = core_f;
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    if (s_q == OP_SHLADD) begin
                        sh_d = {sh_q[W-2:0], 1'b0};
                    end else begin
                        sh_d = {sh_q[W-1], sh_q[W-1:1]};
                    end
                    cnt_d = cnt_q - NW'(1);
                end else begin
                    w_d     = core_w;
                    fl_d    = core_f;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= OP_ADC;
            ci_q    <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            fl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            ci_q    <= ci_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            fl_q    <= fl_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign w    = w_q;
    assign co   = fl_q.co;
    assign ov   = fl_q.ov;
    assign z    = fl_q.z;
    assign neg  = fl_q.neg;
    assign agb  = fl_q.agb;
    assign eq   = fl_q.eq;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq at W=8: directed vector table, random ops vs a
// plain-arithmetic model, back-to-back issue and mid-shift reset abort.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] s = '0;
    logic [2:0] n = '0;
    logic       ci = 1'b0;
    logic       ready, done;
    logic [7:0] w;
    logic       co, ov, z, neg, agb, eq;

    int n_chk = 0;
    int n_pass = 0;

    alu_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s),
        .n(n), .ci(ci), .ready(ready), .done(done), .w(w), .co(co),
        .ov(ov), .z(z), .neg(neg), .agb(agb), .eq(eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int fl;   // {co,ov,z,neg,agb,eq}
        int lat;
    } exp_t;

    typedef struct {
        int s, a, b, n, ci;
        int w, co, ov, neg, lat;
    } vec_t;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: exact integer arithmetic, then wrap to 8 bits.
    function automatic exp_t model(input int op, input int av, input int bv,
                                   input int nv, input int cv);
        exp_t e;
        int sa, sb, ex, u, c, o, wv;
        sa = sx(av);
        sb = sx(bv);
        c  = 0;
        ex = 0;
        case (op)
            0: begin u = av + bv + cv; c = (u >> 8) & 1; ex = sa + sb + cv; end
            1: begin u = av + bv; c = (u >> 8) & 1; ex = sa + sb; end
            2: ex = (sa > sb) ? sa : sb;
            3: ex = sa + sx((av << nv) & 255);
            4: ex = sa + (sa >>> nv);
            5: ex = (sa < 0) ? -sa : sa;
            6: begin u = av + 2 * bv; c = (u >> 8) & 1; ex = sa + 2 * sb; end
            default: ex = av & bv;
        endcase
        o  = (op != 7) && ((ex < -128) || (ex > 127));
        wv = ex & 255;
        e.w   = wv;
        e.fl  = (c << 5) | (o << 4) | ((wv == 0) << 3) | (((wv >> 7) & 1) << 2)
              | ((sa > sb) << 1) | (av == bv);
        e.lat = (op == 3 || op == 4) ? 2 + nv : 1;
        return e;
    endfunction

    function automatic int flags();
        return {26'd0, co, ov, z, neg, agb, eq};
    endfunction

    task automatic run_op(input int op, input int av, input int bv,
                          input int nv, input int cv,
                          output int lat, output int rdy_low);
        @(negedge clk);
        chk("ready_before_accept", int'(ready), 1);
        s = 3'(op); a = 8'(av); b = 8'(bv); n = 3'(nv); ci = 1'(cv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); n = 3'($urandom);
        ci = 1'($urandom); s = 3'($urandom);
        lat = 0;
        rdy_low = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!ready) rdy_low++;
        end
    endtask

    vec_t vt[$];

    initial begin
        int lat, rl;
        exp_t e;
        bit seen;
        int ops1[6] = '{0, 1, 2, 5, 6, 7};

        vt.push_back('{0, 'h7F, 'h01, 0, 1, 'h81, 0, 1, 1, 1});
        vt.push_back('{3, 'h03, 'h00, 2, 0, 'h0F, 0, 0, 0, 4});
        vt.push_back('{4, 'hF0, 'h00, 3, 0, 'hEE, 0, 0, 1, 5});
        vt.push_back('{4, 'hF0, 'h00, 0, 0, 'hE0, 0, 0, 1, 2});
        vt.push_back('{5, 'h80, 'h00, 0, 0, 'h80, 0, 1, 1, 1});
        vt.push_back('{5, 'hFB, 'h00, 0, 0, 'h05, 0, 0, 0, 1});
        vt.push_back('{6, 'hFF, 'h80, 0, 0, 'hFF, 1, 1, 1, 1});
        vt.push_back('{6, 'h10, 'h20, 0, 0, 'h50, 0, 0, 0, 1});
        vt.push_back('{7, 'hF0, 'h3C, 0, 0, 'h30, 0, 0, 0, 1});
        vt.push_back('{1, 'hFF, 'h01, 0, 1, 'h00, 1, 0, 0, 1});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w", int'(w), 0);
        chk("rst_flags", flags(), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(ready), 1);

        // Directed table
        foreach (vt[i]) begin
            run_op(vt[i].s, vt[i].a, vt[i].b, vt[i].n, vt[i].ci, lat, rl);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_w", i), int'(w), vt[i].w);
            chk($sformatf("vec%0d_co", i), int'(co), vt[i].co);
            chk($sformatf("vec%0d_ov", i), int'(ov), vt[i].ov);
            chk($sformatf("vec%0d_neg", i), int'(neg), vt[i].neg);
            chk($sformatf("vec%0d_busy", i), rl, vt[i].lat - 1);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), int'(done), 0);
        end

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            int op, av, bv, nv, cv;
            op = $urandom_range(0, 7);
            av = $urandom_range(0, 255);
            bv = (i % 10 == 0) ? av : $urandom_range(0, 255);
            nv = $urandom_range(0, 7);
            cv = $urandom_range(0, 1);
            e = model(op, av, bv, nv, cv);
            run_op(op, av, bv, nv, cv, lat, rl);
            chk($sformatf("rnd%0d_op%0d_lat", i, op), lat, e.lat);
            chk($sformatf("rnd%0d_op%0d_w", i, op), int'(w), e.w);
            chk($sformatf("rnd%0d_op%0d_flags", i, op), flags(), e.fl);
        end

        // Back-to-back single-cycle ops: done every cycle
        begin
            exp_t prev;
            for (int i = 0; i < 6; i++) begin
                int av, bv, cv;
                av = $urandom_range(0, 255);
                bv = $urandom_range(0, 255);
                cv = $urandom_range(0, 1);
                @(negedge clk);
                if (i > 0) begin
                    chk($sformatf("b2b%0d_done", i), int'(done), 1);
                    chk($sformatf("b2b%0d_w", i), int'(w), prev.w);
                    chk($sformatf("b2b%0d_flags", i), flags(), prev.fl);
                end
                chk($sformatf("b2b%0d_ready", i), int'(ready), 1);
                s = 3'(ops1[i]); a = 8'(av); b = 8'(bv); ci = 1'(cv);
                start = 1'b1;
                prev = model(ops1[i], av, bv, 0, cv);
            end
            @(negedge clk);
            start = 1'b0;
            chk("b2b_last_done", int'(done), 1);
            chk("b2b_last_w", int'(w), prev.w);
            @(negedge clk);
            chk("b2b_idle_done", int'(done), 0);
        end

        // Mid-shift reset abort, with an ignored start during SHIFT
        @(negedge clk);
        s = 3'd3; a = 8'h11; b = 8'h22; n = 3'd7; ci = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (k == 1) begin
                chk("abort_busy", int'(ready), 0);
                s = 3'd0; a = 8'h01; b = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 3) begin
                rst = 1'b1;
                #1;
                chk("abort_ready_in_rst", int'(ready), 0);
            end
            if (k == 4) begin
                chk("abort_w", int'(w), 0);
                chk("abort_flags", flags(), 0);
                rst = 1'b0;
                #1;
                chk("abort_ready_after", int'(ready), 1);
            end
        end
        chk("abort_no_done", int'(seen), 0);

        run_op(2, 'h80, 'h7F, 0, 0, lat, rl);
        chk("max_lat", lat, 1);
        chk("max_w", int'(w), 'h7F);
        chk("max_agb", int'(agb), 0);
        chk("max_eq", int'(eq), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same eight operations and status flags, generalised to width `W`. Operations 3 and 4 use an iterative one-bit-per-cycle shifter instead of a barrel shifter, so `n` sets the latency. Operands are latched on `start`; results and flags are registered and held until the next completion. The block sits between the control FSM and the register file of the CA datapath.

## Interface
- `W`, 8, operand/result width (≥4)
- `NW`, `$clog2(W)`, width of shift amount
- `clk` in 1: rising-edge clock
- `rst` in 1: reset, synchronous and active-high
- `start` in 1: request; accepted only when `ready`=1
- `a`, `b` in W: signed operands, latched on accept
- `s` in 3: opcode, latched on accept
- `n` in NW: shift amount for ops 3/4, latched on accept
- `ci` in 1: carry-in for op 0, latched on accept
- `ready` out 1: idle, able to accept
- `done` out 1: one-cycle pulse; results valid from this cycle
- `w` out W: result, held until next `done`
- `co`, `ov`, `z`, `neg`, `agb`, `eq` out 1: registered flags, updated only with `done`

## Operation
- FSM states:
  - IDLE: on accepted `start`, latch the operands, `s`, `n` and `ci`.
    - s∈{3,4}: go to SHIFT; `sh`←a_r, `cnt`←n_r.
    - otherwise: compute, register the outputs, pulse `done`, stay in IDLE.
  - SHIFT: each cycle with `cnt`≠0:
    - s=3: `sh`←`sh`<<<1; s=4: `sh`←`sh`>>>1 (arithmetic).
    - `cnt`−1.
    - When `cnt`=0, register w=a_r+`sh`, pulse `done`, return to IDLE.
- Ops (all arithmetic mod 2^W):
  - 0: a+b+ci; co = bit W of unsigned (W+1)-bit sum.
  - 1: a+b; co as op 0.
  - 2: signed max(a,b); co=0.
  - 3: a+trunc_W(a<<<n). Bits shifted out are lost.
  - 4: a+(a>>>n).
  - 5: abs(a). For a=most-negative, w=a and ov=1.
  - 6: a+2b; co = bit W of unsigned (W+1)-bit sum a+b+b; ov = exact signed result not representable in W bits.
  - 7: a&b.
- `ov`:
  - ops 0, 1, 3, 4: signed overflow of the final W-bit addition.
  - ops 2, 7: 0.
  - op 5: as stated under op 5.
  - op 6: as stated under op 6.
- `co`: 0 for ops 2–5 and 7.
- `z` = (w==0); `neg` = w[W-1]; `agb` = signed a_r>b_r; `eq` = (a_r==b_r).

## Timing
- `ready` = (state==IDLE) && !`rst` (combinational).
- Latency, accept edge t → `done` high in cycle:
  - ops 0, 1, 2, 5, 6, 7: t+1.
  - ops 3, 4: t+2+n (n=0 gives t+2).
- `start` while `ready`=0 is ignored (no queueing). `start` in a `done` cycle is accepted; the outputs keep the old result until the new `done`.
- Operand inputs may change freely after the accept edge.
- Reset (any state, including mid-SHIFT):
  - next edge gives state IDLE; `w`, all flags, `done`, `sh` and `cnt` = 0.
  - the aborted op never produces `done`.
  - `ready`=1 from the first cycle after `rst` deasserts.
- `done` is never high in two consecutive cycles for shift ops. Single-cycle ops issued back-to-back give `done` every cycle.

## Structure
- Package `alu_pkg`:
  - opcode enum (OP_ADC, OP_ADD, OP_MAX, OP_SHLADD, OP_SHRADD, OP_ABS, OP_ADD2B, OP_AND).
  - state enum (IDLE, SHIFT).
  - flag struct.
- Sub-module `alu_core`: combinational W-parametrised result/flag computation from (a_r, b_r, `sh`, s, ci). It is shared by IDLE completion and SHIFT completion.
- The top level holds the FSM, operand registers, shifter and output registers.

## Test plan (W=8)
- `rst`, then s=0, a=0x7F, b=0x01, ci=1 → `done` at t+1; w=0x81, ov=1, co=0, neg=1, agb=1.
- s=3, a=0x03, n=2 → `ready`=0 for t+1..t+3; `done` at t+4; w=0x0F, ov=0.
- s=4, a=0xF0, n=3 → `done` at t+5; w=0xEE, neg=1, ov=0. Then s=4 with n=0 → `done` at t+2, w=0xE0.
- s=5: a=0x80 → w=0x80, ov=1. s=5: a=0xFB → w=0x05, ov=0.
- s=6: a=0xFF, b=0x80 → w=0xFF, co=1, ov=1. s=6: a=0x10, b=0x20 → w=0x50, co=0, ov=0.
- s=3, n=7; `start` pulsed again during SHIFT (ignored); `rst` asserted 3 cycles after accept → no `done`; w=0 and all flags 0; `ready`=1 the cycle after `rst` drops. Then s=2, a=0x80, b=0x7F → w=0x7F, agb=0, eq=0.
